revelador_casillas: RTL

Flood-reveal sequencer for the 8x8 buscaminas board. On a selected cell it reveals that cell. If the cell has zero adjacent mines, it walks all connected zero-cells breadth-first and reveals their in-bounds neighbours. It owns the board's single read/write port for the duration of a reveal and sits between the game FSM (start/done) and the board storage.

---
 rtl/revelador_casillas.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/revelador_casillas.sv
// Flood-reveal sequencer for the 8x8 buscaminas board: reveals the selected cell and,
// for zero-count cells, walks connected zero regions breadth-first through an internal FIFO.
module revelador_casillas #(
    parameter int FILAS    = 8,
    parameter int COLUMNAS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] i_in,
    input  logic [2:0] j_in,
    output logic [2:0] rd_i,
    output logic [2:0] rd_j,
    input  logic [6:0] rd_data,
    output logic       wr_en,
    output logic [2:0] wr_i,
    output logic [2:0] wr_j,
    output logic [6:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       mine_hit,
    output logic [6:0] revealed_count
);

    localparam int CELDAS = FILAS * COLUMNAS;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        EVAL  = 3'd2,
        NEIGH = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         fifo_q [CELDAS];
    logic [5:0]         head_q, head_d;
    logic [5:0]         tail_q, tail_d;
    logic [6:0]         occ_q, occ_d;
    logic [CELDAS-1:0]  visited_q, visited_d;
    logic [2:0]         cur_i_q, cur_i_d;
    logic [2:0]         cur_j_q, cur_j_d;
    logic [2:0]         k_q, k_d;
    logic               mine_hit_q, mine_hit_d;
    logic [6:0]         count_q, count_d;

    logic               enq_en;
    logic [5:0]         enq_addr;
    logic [5:0]         enq_data;
    logic signed [3:0]  di, dj, ni, nj;
    logic [5:0]         n_idx;

    assign rd_i           = cur_i_q;
    assign rd_j           = cur_j_q;
    assign wr_i           = cur_i_q;
    assign wr_j           = cur_j_q;
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign mine_hit       = mine_hit_q;
    assign revealed_count = count_q;

    // Neighbour offsets in row-major order; an out-of-range coordinate (-1 or 8) sets bit 3.
    always_comb begin
        di = 4'sd0;
        dj = 4'sd0;
        case (k_q)
            3'd0: begin di = -4'sd1; dj = -4'sd1; end
            3'd1: begin di = -4'sd1; dj =  4'sd0; end
            3'd2: begin di = -4'sd1; dj =  4'sd1; end
            3'd3: begin di =  4'sd0; dj = -4'sd1; end
            3'd4: begin di =  4'sd0; dj =  4'sd1; end
            3'd5: begin di =  4'sd1; dj = -4'sd1; end
            3'd6: begin di =  4'sd1; dj =  4'sd0; end
            default: begin di = 4'sd1; dj = 4'sd1; end
        endcase
        ni    = $signed({1'b0, cur_i_q}) + di;
        nj    = $signed({1'b0, cur_j_q}) + dj;
        n_idx = {ni[2:0], nj[2:0]};
    end

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        occ_d      = occ_q;
        visited_d  = visited_q;
        cur_i_d    = cur_i_q;
        cur_j_d    = cur_j_q;
        k_d        = k_q;
        mine_hit_d = mine_hit_q;
        count_d    = count_q;
        enq_en     = 1'b0;
        enq_addr   = tail_q;
        enq_data   = 6'd0;
        wr_en      = 1'b0;
        wr_data    = rd_data | 7'b1000000;

        case (state_q)
            IDLE: begin
                if (start) begin
                    visited_d                 = '0;
                    visited_d[{i_in, j_in}]   = 1'b1;
                    enq_en                    = 1'b1;
                    enq_addr                  = 6'd0;
                    enq_data                  = {i_in, j_in};
                    head_d                    = 6'd0;
                    tail_d                    = 6'd1;
                    occ_d                     = 7'd1;
                    count_d                   = 7'd0;
                    mine_hit_d                = 1'b0;
                    state_d                   = POP;
                end
            end
            POP: begin
                if (occ_q == 7'd0) begin
                    state_d = DONE;
                end else begin
                    {cur_i_d, cur_j_d} = fifo_q[head_q];
                    head_d             = head_q + 6'd1;
                    occ_d              = occ_q - 7'd1;
                    state_d            = EVAL;
                end
            end
            EVAL: begin
                if (rd_data[6] || rd_data[5]) begin
                    state_d = POP;
                end else begin
                    wr_en   = 1'b1;
                    count_d = count_q + 7'd1;
                    if (rd_data[4]) begin
                        mine_hit_d = 1'b1;
                        state_d    = DONE;
                    end else if (rd_data[3:0] == 4'd0) begin
                        k_d     = 3'd0;
                        state_d = NEIGH;
                    end else begin
                        state_d = POP;
                    end
                end
            end
            NEIGH: begin
                if (!ni[3] && !nj[3] && !visited_q[n_idx]) begin
                    enq_en           = 1'b1;
                    enq_addr         = tail_q;
                    enq_data         = n_idx;
                    tail_d           = tail_q + 6'd1;
                    occ_d            = occ_q + 7'd1;
                    visited_d[n_idx] = 1'b1;
                end
                k_d = k_q + 3'd1;
                if (k_q == 3'd7) begin
                    state_d = POP;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            head_q     <= 6'd0;
            tail_q     <= 6'd0;
            occ_q      <= 7'd0;
            visited_q  <= '0;
            cur_i_q    <= 3'd0;
            cur_j_q    <= 3'd0;
            k_q        <= 3'd0;
            mine_hit_q <= 1'b0;
            count_q    <= 7'd0;
            for (int n = 0; n < CELDAS; n++) begin
                fifo_q[n] <= 6'd0;
            end
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            visited_q  <= visited_d;
            cur_i_q    <= cur_i_d;
            cur_j_q    <= cur_j_d;
            k_q        <= k_d;
            mine_hit_q <= mine_hit_d;
            count_q    <= count_d;
            if (enq_en) begin
                fifo_q[enq_addr] <= enq_data;
            end
        end
    end

endmodule
